// File: rtl/sdram_resp_pkg.sv
// Shared definitions for the SDRAM command responder: command encodings,
// bank state, err bit positions, burst descriptor and index/column helpers.
package sdram_resp_pkg;

    // {csn, rasn, casn, wen}
    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_BST   = 4'b0110;
    localparam logic [3:0] CMD_NOP   = 4'b0111;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_t;

    localparam int unsigned ERR_NO_MODE     = 0;
    localparam int unsigned ERR_BANK_IDLE   = 1;
    localparam int unsigned ERR_BANK_ACTIVE = 2;
    localparam int unsigned ERR_REF_ACTIVE  = 3;
    localparam int unsigned ERR_TRCD        = 4;
    localparam int unsigned ERR_TRP         = 5;

    // One read or write burst in flight; left == 0 means no burst.
    typedef struct packed {
        logic [3:0]  left;
        logic [1:0]  ba;
        logic [12:0] row;
        logic [8:0]  col;
        logic [2:0]  mask;
        logic        ap;
    } burst_t;

    // Sequential column advance wrapping inside the BL-aligned block.
    function automatic logic [8:0] burst_next_col(input logic [8:0] col, input logic [2:0] mask);
        logic [8:0] m9;
        m9 = {6'd0, mask};
        return (col & ~m9) | ((col + 9'd1) & m9);
    endfunction

    // Full storage index before truncation to the configured depth.
    function automatic logic [23:0] mem_index(input logic [1:0] ba, input logic [12:0] row,
                                              input logic [8:0] col);
        return {ba, row, col};
    endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// 16-bit word storage: one byte-enabled write port, one registered read port.
// Contents are not reset.
module sdram_resp_mem
    import sdram_resp_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [0:(1<<AW)-1];

    // Byte-masked write
    always_ff @(posedge clk) begin
        if (we && be[0]) mem[waddr][7:0]  <= wdata[7:0];
        if (we && be[1]) mem[waddr][15:8] <= wdata[15:8];
    end

    // Registered read, held when not enabled
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sdram_cmd_responder.sv
// SDRAM device-side command responder: decodes controller commands, tracks
// bank state, serves read/write bursts from internal storage and flags
// protocol errors. Define SDRAM_RESP_TIMING_CHECK_EN to enable tRCD/tRP checks.
module sdram_cmd_responder
    import sdram_resp_pkg::*;
#(
    parameter int unsigned MEM_AW   = 12,
    parameter int unsigned MAX_CAS  = 3,
    parameter int unsigned TRCD_CYC = 2,
    parameter int unsigned TRP_CYC  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sdram_cke,
    input  logic        sdram_csn,
    input  logic        sdram_rasn,
    input  logic        sdram_casn,
    input  logic        sdram_wen,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_addr,
    input  logic [1:0]  sdram_dqm,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic [12:0] mode_reg,
    output logic        mode_valid,
    output logic [15:0] ref_count,
    output logic [5:0]  err
);

    if (MAX_CAS < 1 || MAX_CAS > 7 || TRCD_CYC > 255 || TRP_CYC > 255 || MEM_AW > 24) begin : g_param_check
        $error("sdram_cmd_responder: unsupported parameter set");
    end

    bank_state_t bank_st  [4];
    logic [12:0] bank_row [4];
    logic [3:0]  err_q;
    burst_t      rd_q, wr_q, pend_q;
    logic        pend_vld;
    logic [3:0]  pend_wait;
    logic [1:0]  dqm_d;
    logic        beat_vld;
    logic [15:0] rdata;

    logic [3:0]  cmd;
    logic        is_mrs, is_act, is_rd, is_wr, is_pre, is_ref, is_bst;
    logic [2:0]  cas;
    logic [3:0]  bl_len;
    logic [2:0]  bl_mask;
    logic        mode_ok, bank_act, any_act, trcd_bad, rw_ok, rd_go, wr_go;
    burst_t      new_b, pend_eff, rd_eff, rd_nxt, wr_eff, wr_nxt;
    logic        pend_eff_vld, pend_start, pend_nxt_vld;
    logic [3:0]  pend_eff_wait;
    logic        rd_issue, rd_close, wr_issue, wr_close;
    logic [MEM_AW-1:0] rd_addr, wr_addr;

    // Command decode; nothing is sampled while cke is low
    always_comb begin
        cmd    = {sdram_csn, sdram_rasn, sdram_casn, sdram_wen};
        is_mrs = sdram_cke && (cmd == CMD_MRS);
        is_act = sdram_cke && (cmd == CMD_ACT);
        is_rd  = sdram_cke && (cmd == CMD_READ);
        is_wr  = sdram_cke && (cmd == CMD_WRITE);
        is_pre = sdram_cke && (cmd == CMD_PRE);
        is_ref = sdram_cke && (cmd == CMD_REF);
        is_bst = sdram_cke && (cmd == CMD_BST);
    end

    // Mode fields and command legality
    always_comb begin
        cas = mode_reg[6:4];
        case (mode_reg[1:0])
            2'd0:    begin bl_len = 4'd1; bl_mask = 3'b000; end
            2'd1:    begin bl_len = 4'd2; bl_mask = 3'b001; end
            2'd2:    begin bl_len = 4'd4; bl_mask = 3'b011; end
            default: begin bl_len = 4'd8; bl_mask = 3'b111; end
        endcase
        mode_ok = (sdram_addr[6:4] != 3'd0) && (32'(sdram_addr[6:4]) <= MAX_CAS)
               && (sdram_addr[2:0] <= 3'd3);
        bank_act = (bank_st[sdram_ba] == BANK_ACTIVE);
        any_act  = 1'b0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (bank_st[b] == BANK_ACTIVE) any_act = 1'b1;
        end
        rw_ok = mode_valid && bank_act && !trcd_bad;
        rd_go = is_rd && rw_ok;
        wr_go = is_wr && rw_ok;
    end

    // Burst generators. A new READ waits CAS-1 edges in the pending slot and
    // only then replaces the running read, so old beats keep flowing until
    // the new burst's first beat takes the bus.
    always_comb begin
        new_b = '{left: bl_len, ba: sdram_ba, row: bank_row[sdram_ba],
                  col: sdram_addr[8:0], mask: bl_mask, ap: sdram_addr[10]};

        pend_eff_vld  = pend_vld && !(wr_go || is_bst);
        pend_eff      = pend_q;
        pend_eff_wait = pend_wait;
        if (rd_go) begin
            pend_eff_vld  = 1'b1;
            pend_eff      = new_b;
            pend_eff_wait = {1'b0, cas} - 4'd1;
        end
        pend_start   = pend_eff_vld && (pend_eff_wait == 4'd0);
        pend_nxt_vld = pend_eff_vld && !pend_start;

        rd_eff = rd_q;
        if (wr_go || is_bst) rd_eff.left = '0;
        if (pend_start) rd_eff = pend_eff;
        rd_issue = sdram_cke && (rd_eff.left != 4'd0);
        rd_close = rd_issue && (rd_eff.left == 4'd1) && rd_eff.ap;
        rd_nxt   = rd_eff;
        if (rd_issue) begin
            rd_nxt.left = rd_eff.left - 4'd1;
            rd_nxt.col  = burst_next_col(rd_eff.col, rd_eff.mask);
        end

        wr_eff = wr_q;
        if (rd_go || is_bst) wr_eff.left = '0;
        if (wr_go) wr_eff = new_b;
        wr_issue = sdram_cke && (wr_eff.left != 4'd0);
        wr_close = wr_issue && (wr_eff.left == 4'd1) && wr_eff.ap;
        wr_nxt   = wr_eff;
        if (wr_issue) begin
            wr_nxt.left = wr_eff.left - 4'd1;
            wr_nxt.col  = burst_next_col(wr_eff.col, wr_eff.mask);
        end

        rd_addr = MEM_AW'(mem_index(rd_eff.ba, rd_eff.row, rd_eff.col));
        wr_addr = MEM_AW'(mem_index(wr_eff.ba, wr_eff.row, wr_eff.col));
    end

    // Protocol state, burst registers and output enable
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned b = 0; b < 4; b++) begin
                bank_st[b]  <= BANK_IDLE;
                bank_row[b] <= '0;
            end
            mode_reg   <= '0;
            mode_valid <= 1'b0;
            ref_count  <= '0;
            err_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            pend_q     <= '0;
            pend_vld   <= 1'b0;
            pend_wait  <= '0;
            dqm_d      <= '0;
            beat_vld   <= 1'b0;
            dq_oe      <= 1'b0;
        end else if (sdram_cke) begin
            rd_q      <= rd_nxt;
            wr_q      <= wr_nxt;
            pend_q    <= pend_eff;
            pend_vld  <= pend_nxt_vld;
            pend_wait <= pend_eff_wait - 4'd1;
            dqm_d     <= sdram_dqm;
            beat_vld  <= rd_issue;
            dq_oe     <= rd_issue && !(|dqm_d);

            if (is_mrs) begin
                mode_reg   <= sdram_addr;
                mode_valid <= mode_ok;
                if (!mode_ok) err_q[ERR_NO_MODE] <= 1'b1;
            end
            if (is_ref) begin
                ref_count <= ref_count + 16'd1;
                if (any_act) err_q[ERR_REF_ACTIVE] <= 1'b1;
            end
            if ((is_act || is_rd || is_wr) && !mode_valid) err_q[ERR_NO_MODE] <= 1'b1;
            if ((is_rd || is_wr) && !bank_act) err_q[ERR_BANK_IDLE] <= 1'b1;
            if (is_act && bank_act) err_q[ERR_BANK_ACTIVE] <= 1'b1;

            if (rd_close) bank_st[rd_eff.ba] <= BANK_IDLE;
            if (wr_close) bank_st[wr_eff.ba] <= BANK_IDLE;
            if (is_pre) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (sdram_addr[10] || (sdram_ba == 2'(b))) bank_st[b] <= BANK_IDLE;
                end
            end
            if (is_act && !bank_act) begin
                bank_st[sdram_ba]  <= BANK_ACTIVE;
                bank_row[sdram_ba] <= sdram_addr;
            end
        end
    end

`ifdef SDRAM_RESP_TIMING_CHECK_EN
    logic [7:0] act_cnt [4];
    logic [7:0] pre_cnt [4];
    logic [1:0] err_t;
    logic       trp_bad;

    // Elapsed-cycle checks for the addressed bank
    always_comb begin
        trcd_bad = act_cnt[sdram_ba] < 8'(TRCD_CYC);
        trp_bad  = pre_cnt[sdram_ba] < 8'(TRP_CYC);
    end

    // Saturating per-bank counters since ACT and since (auto)precharge
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned b = 0; b < 4; b++) begin
                act_cnt[b] <= '1;
                pre_cnt[b] <= '1;
            end
            err_t <= '0;
        end else begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (act_cnt[b] != 8'hFF) act_cnt[b] <= act_cnt[b] + 8'd1;
                if (pre_cnt[b] != 8'hFF) pre_cnt[b] <= pre_cnt[b] + 8'd1;
                if (is_pre && (sdram_addr[10] || (sdram_ba == 2'(b)))) pre_cnt[b] <= 8'd1;
            end
            if (rd_close) pre_cnt[rd_eff.ba] <= 8'd1;
            if (wr_close) pre_cnt[wr_eff.ba] <= 8'd1;
            if (is_act && !bank_act) act_cnt[sdram_ba] <= 8'd1;
            if ((is_rd || is_wr) && trcd_bad) err_t[ERR_TRCD-4] <= 1'b1;
            if (is_act && trp_bad) err_t[ERR_TRP-4] <= 1'b1;
        end
    end

    assign err = {err_t, err_q};
`else
    assign trcd_bad = 1'b0;
    assign err      = {2'b00, err_q};
`endif

    assign dq_out = beat_vld ? rdata : '0;

    sdram_resp_mem #(.AW(MEM_AW)) u_mem (
        .clk   (clk),
        .we    (wr_issue),
        .be    (~sdram_dqm),
        .waddr (wr_addr),
        .wdata (dq_in),
        .re    (rd_issue),
        .raddr (rd_addr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed self-checking bench for sdram_cmd_responder (default parameters).
module tb_sdram_cmd_responder;

    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_NOP = 4'b0111;

`ifdef SDRAM_RESP_TIMING_CHECK_EN
    localparam logic [5:0] E_TRCD = 6'h10;
`else
    localparam logic [5:0] E_TRCD = 6'h00;
`endif

    logic        clk = 1'b0;
    logic        resetn, sdram_cke, sdram_csn, sdram_rasn, sdram_casn, sdram_wen;
    logic [1:0]  sdram_ba, sdram_dqm;
    logic [12:0] sdram_addr;
    logic [15:0] dq_in, dq_out, ref_count;
    logic        dq_oe, mode_valid;
    logic [12:0] mode_reg;
    logic [5:0]  err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdram_cmd_responder dut (
        .clk        (clk),
        .resetn     (resetn),
        .sdram_cke  (sdram_cke),
        .sdram_csn  (sdram_csn),
        .sdram_rasn (sdram_rasn),
        .sdram_casn (sdram_casn),
        .sdram_wen  (sdram_wen),
        .sdram_ba   (sdram_ba),
        .sdram_addr (sdram_addr),
        .sdram_dqm  (sdram_dqm),
        .dq_in      (dq_in),
        .dq_out     (dq_out),
        .dq_oe      (dq_oe),
        .mode_reg   (mode_reg),
        .mode_valid (mode_valid),
        .ref_count  (ref_count),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one command for one edge; returns 1 ns after that edge.
    task automatic step(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                        input logic [15:0] d, input logic [1:0] m);
        {sdram_csn, sdram_rasn, sdram_casn, sdram_wen} = c;
        sdram_ba   = ba;
        sdram_addr = a;
        dq_in      = d;
        sdram_dqm  = m;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic [15:0] d);
        step(C_NOP, 2'd0, 13'd0, d, 2'b00);
    endtask

    initial begin
        resetn    = 1'b0;
        sdram_cke = 1'b1;
        step(C_NOP, 0, 0, 0, 0);
        nop(0);
        nop(0);
        chk("rst_mode_reg", 32'(mode_reg), 32'h0);
        chk("rst_mode_valid", 32'(mode_valid), 32'h0);
        chk("rst_ref_count", 32'(ref_count), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_dq_oe", 32'(dq_oe), 32'h0);
        chk("rst_dq_out", 32'(dq_out), 32'h0);
        resetn = 1'b1;
        nop(0);

        // Refresh with all banks idle; cke low suppresses the fourth
        step(C_REF, 0, 0, 0, 0);
        step(C_REF, 0, 0, 0, 0);
        step(C_REF, 0, 0, 0, 0);
        chk("ref_count3", 32'(ref_count), 32'h3);
        chk("ref_err0", 32'(err), 32'h0);
        sdram_cke = 1'b0;
        step(C_REF, 0, 0, 0, 0);
        sdram_cke = 1'b1;
        chk("ref_cke_low", 32'(ref_count), 32'h3);

        // CAS2 BL2
        step(C_MRS, 0, 13'h021, 0, 0);
        chk("mrs_valid", 32'(mode_valid), 32'h1);
        chk("mrs_reg", 32'(mode_reg), 32'h021);
        chk("mrs_err", 32'(err), 32'h0);

        step(C_ACT, 2'd1, 13'd3, 0, 0);
        nop(0);
        nop(0);
        step(C_WR, 2'd1, 13'd4, 16'h5555, 2'b00);
        nop(16'h6677);
        nop(0);
        step(C_WR, 2'd1, 13'd4, 16'h1234, 2'b00);
        step(C_NOP, 0, 0, 16'hABCD, 2'b01);
        nop(0);
        step(C_RD, 2'd1, 13'd4, 0, 0);
        nop(0);
        chk("rd_b0_oe", 32'(dq_oe), 32'h1);
        chk("rd_b0_data", 32'(dq_out), 32'h1234);
        nop(0);
        chk("rd_b1_oe", 32'(dq_oe), 32'h1);
        chk("rd_b1_data", 32'(dq_out), 32'hAB77);
        nop(0);
        chk("rd_end_oe", 32'(dq_oe), 32'h0);
        chk("rd_err", 32'(err), 32'h0);

        // READ one cycle after ACT
        step(C_ACT, 2'd2, 13'd1, 0, 0);
        step(C_RD, 2'd2, 13'd0, 0, 0);
        chk("trcd_err", 32'(err), 32'(E_TRCD));
        nop(0);
`ifdef SDRAM_RESP_TIMING_CHECK_EN
        chk("trcd_no_oe_a", 32'(dq_oe), 32'h0);
        nop(0);
        chk("trcd_no_oe_b", 32'(dq_oe), 32'h0);
`else
        nop(0);
`endif
        nop(0);
        nop(0);

        // CAS2 BL4
        step(C_MRS, 0, 13'h022, 0, 0);
        chk("mrs4_reg", 32'(mode_reg), 32'h022);
        chk("mrs4_valid", 32'(mode_valid), 32'h1);
        step(C_WR, 2'd1, 13'd4, 16'h0404, 2'b00);
        nop(16'h0505);
        nop(16'h0606);
        nop(16'h0707);
        step(C_WR, 2'd1, 13'd8, 16'h0808, 2'b00);
        nop(16'h0909);
        nop(16'h0A0A);
        nop(16'h0B0B);
        nop(0);

        // Wrap inside the aligned block: 6,7,4,5
        step(C_RD, 2'd1, 13'd6, 0, 0);
        nop(0);
        chk("wrap_b0", 32'(dq_out), 32'h0606);
        nop(0);
        chk("wrap_b1", 32'(dq_out), 32'h0707);
        nop(0);
        chk("wrap_b2", 32'(dq_out), 32'h0404);
        nop(0);
        chk("wrap_b3", 32'(dq_out), 32'h0505);
        chk("wrap_b3_oe", 32'(dq_oe), 32'h1);
        nop(0);
        chk("wrap_end_oe", 32'(dq_oe), 32'h0);

        // Interrupt after beat 1: 6,7 then 8,9
        step(C_RD, 2'd1, 13'd6, 0, 0);
        nop(0);
        chk("intr_b0", 32'(dq_out), 32'h0606);
        step(C_RD, 2'd1, 13'd8, 0, 0);
        chk("intr_b1", 32'(dq_out), 32'h0707);
        nop(0);
        chk("intr_new0", 32'(dq_out), 32'h0808);
        nop(0);
        chk("intr_new1", 32'(dq_out), 32'h0909);
        nop(0);
        nop(0);
        nop(0);

        // Reset mid-burst
        step(C_RD, 2'd1, 13'd8, 0, 0);
        nop(0);
        chk("mid_b0", 32'(dq_out), 32'h0808);
        chk("mid_b0_oe", 32'(dq_oe), 32'h1);
        resetn = 1'b0;
        nop(0);
        chk("mid_rst_oe", 32'(dq_oe), 32'h0);
        chk("mid_rst_dq", 32'(dq_out), 32'h0);
        nop(0);
        resetn = 1'b1;
        nop(0);
        chk("post_rst_err", 32'(err), 32'h0);
        chk("post_rst_valid", 32'(mode_valid), 32'h0);

        // Storage survives reset
        step(C_MRS, 0, 13'h021, 0, 0);
        step(C_ACT, 2'd1, 13'd3, 0, 0);
        nop(0);
        nop(0);
        step(C_RD, 2'd1, 13'd4, 0, 0);
        nop(0);
        chk("keep_b0", 32'(dq_out), 32'h0404);
        nop(0);
        chk("keep_b1", 32'(dq_out), 32'h0505);
        nop(0);

        // Auto-precharge read leaves all banks idle
        step(C_RD, 2'd1, 13'h404, 0, 0);
        nop(0);
        chk("ap_b0", 32'(dq_out), 32'h0404);
        nop(0);
        chk("ap_b1", 32'(dq_out), 32'h0505);
        nop(0);
        step(C_REF, 0, 0, 0, 0);
        chk("ap_ref_count", 32'(ref_count), 32'h1);
        chk("ap_ref_err", 32'(err), 32'h0);

        // READ to idle bank
        step(C_RD, 2'd1, 13'd4, 0, 0);
        chk("idle_rd_err", 32'(err), 32'h02);
        nop(0);
        chk("idle_rd_oe_a", 32'(dq_oe), 32'h0);
        nop(0);
        chk("idle_rd_oe_b", 32'(dq_oe), 32'h0);

        // REF with a bank active, ACT to active bank, illegal CAS
        step(C_ACT, 2'd0, 13'd0, 0, 0);
        nop(0);
        nop(0);
        step(C_REF, 0, 0, 0, 0);
        chk("ref_active_err", 32'(err), 32'h0A);
        chk("ref_active_cnt", 32'(ref_count), 32'h2);
        step(C_ACT, 2'd0, 13'd5, 0, 0);
        chk("act_active_err", 32'(err), 32'h0E);
        step(C_MRS, 0, 13'h041, 0, 0);
        chk("bad_cas_valid", 32'(mode_valid), 32'h0);
        chk("bad_cas_err", 32'(err), 32'h0F);
        chk("bad_cas_reg", 32'(mode_reg), 32'h041);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
